// File: rtl/pipelined_cla_adder_32.sv
// Byte-sliced pipelined 32-bit add/subtract unit: one 8-bit carry-look-ahead slice per stage,
// results leave through a valid/ready handshake with a single global advance.
module pipelined_cla_adder_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int unsigned NSLICE = WIDTH / 8;
    localparam int unsigned LAST   = NSLICE - 1;

    // Parallel-prefix carries of one byte: c[i] is the carry out of bit i.
    function automatic logic [7:0] cla8(input logic [7:0] p, input logic [7:0] g,
                                        input logic ci);
        logic [7:0] c;
        logic       t;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c[i] = g[i];
            t    = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (t & g[j]);
                t    = t & p[j];
            end
            c[i] = c[i] | (t & ci);
        end
        return c;
    endfunction

    logic                          adv;
    logic [NSLICE-1:0]             vld_q, vld_d, cy_q, cy_d, as_q, as_d, bs_q, bs_d;
    logic [NSLICE-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [NSLICE-1:0][WIDTH-1:0]  a_src, b_src, s_src;
    logic [NSLICE-1:0]             c_src, v_src, as_src, bs_src;
    logic                          zero_q, zero_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]              b_cond;

    assign adv      = ~vld_q[LAST] | out_ready;
    assign in_ready = adv;
    assign b_cond   = in_sub ? ~in_b : in_b;

    // Stage inputs: stage 0 takes the conditioned operands, stage k takes stage k-1.
    always_comb begin
        a_src     = '0;
        b_src     = '0;
        s_src     = '0;
        c_src     = '0;
        v_src     = '0;
        as_src    = '0;
        bs_src    = '0;
        a_src[0]  = in_a;
        b_src[0]  = b_cond;
        c_src[0]  = in_sub;
        v_src[0]  = in_valid & in_ready;
        as_src[0] = in_a[WIDTH-1];
        bs_src[0] = b_cond[WIDTH-1];
        for (int k = 1; k < int'(NSLICE); k++) begin
            a_src[k]  = a_q[k-1];
            b_src[k]  = b_q[k-1];
            s_src[k]  = sum_q[k-1];
            c_src[k]  = cy_q[k-1];
            v_src[k]  = vld_q[k-1];
            as_src[k] = as_q[k-1];
            bs_src[k] = bs_q[k-1];
        end
    end

    // Each stage resolves its own byte and forwards everything else.
    always_comb begin
        logic [7:0] p;
        logic [7:0] g;
        logic [7:0] c;
        p     = '0;
        g     = '0;
        c     = '0;
        vld_d = v_src;
        as_d  = as_src;
        bs_d  = bs_src;
        a_d   = a_src;
        b_d   = b_src;
        sum_d = s_src;
        cy_d  = '0;
        for (int k = 0; k < int'(NSLICE); k++) begin
            p = a_src[k][8*k +: 8] ^ b_src[k][8*k +: 8];
            g = a_src[k][8*k +: 8] & b_src[k][8*k +: 8];
            c = cla8(p, g, c_src[k]);
            sum_d[k][8*k +: 8] = p ^ {c[6:0], c_src[k]};
            cy_d[k] = c[7];
        end
        zero_d = (sum_d[LAST] == '0);
        ovf_d  = (as_d[LAST] == bs_d[LAST]) && (sum_d[LAST][WIDTH-1] != as_d[LAST]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            cy_q   <= '0;
            as_q   <= '0;
            bs_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            vld_q  <= vld_d;
            cy_q   <= cy_d;
            as_q   <= as_d;
            bs_q   <= bs_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sum_q  <= sum_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = vld_q[LAST];
    assign out_sum   = sum_q[LAST];
    assign out_cout  = cy_q[LAST];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder_32.sv
// Directed bench for pipelined_cla_adder_32: reset, carry chains, subtract/overflow,
// streaming, backpressure and mid-flight reset.
module tb_pipelined_cla_adder_32;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic        out_cout, out_ovf, out_zero;
    logic [31:0] in_a, in_b, out_sum;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    res_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_cla_adder_32 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_zero (out_zero)
    );

    // Reference: plain 33-bit arithmetic on the conditioned operand.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bp;
        logic [32:0] t;
        res_t        r;
        bp     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bp} + 33'(sub);
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (a[31] == bp[31]) && (t[31] != a[31]);
        r.zero = (t[31:0] == 32'h0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_sum !== 32'h0) begin n_fail++; $display("FAIL reset_out_sum got %h want 00000000", out_sum); end
        n_checks++;
        if ({out_cout, out_ovf, out_zero} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000", {out_cout, out_ovf, out_zero});
        end
    endtask

    task automatic test_single_add();
        out_ready = 1'b1;
        send_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early edge %0d got %b want 0", e, out_valid); end
            if (e < 3) tick();
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", out_valid); end
        n_checks++;
        if (out_sum !== 32'h0000_0100) begin n_fail++; $display("FAIL add_sum got %h want 00000100", out_sum); end
        n_checks++;
        if ({out_cout, out_ovf, out_zero} !== 3'b000) begin
            n_fail++; $display("FAIL add_flags got %b want 000", {out_cout, out_ovf, out_zero});
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_bubble got %b want 0", out_valid); end
    endtask

    task automatic test_carry_chain();
        out_ready = 1'b1;
        send_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        repeat (3) tick();
        n_checks++;
        if (out_sum !== 32'h0000_0000) begin n_fail++; $display("FAIL chain_sum got %h want 00000000", out_sum); end
        n_checks++;
        if ({out_valid, out_cout, out_ovf, out_zero} !== 4'b1101) begin
            n_fail++; $display("FAIL chain_flags got %b want 1101", {out_valid, out_cout, out_ovf, out_zero});
        end
        tick();
    endtask

    task automatic test_subtract();
        logic [31:0] va[2];
        logic [31:0] vb[2];
        logic [31:0] esum[2];
        logic [3:0]  eflg[2];
        va   = '{32'h8000_0000, 32'h0000_0005};
        vb   = '{32'h0000_0001, 32'h0000_0007};
        esum = '{32'h7FFF_FFFF, 32'hFFFF_FFFE};
        eflg = '{4'b1110, 4'b1000};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_op(va[i], vb[i], 1'b1);
            repeat (3) tick();
            n_checks++;
            if (out_sum !== esum[i]) begin
                n_fail++; $display("FAIL sub%0d_sum got %h want %h", i, out_sum, esum[i]);
            end
            n_checks++;
            if ({out_valid, out_cout, out_ovf, out_zero} !== eflg[i]) begin
                n_fail++;
                $display("FAIL sub%0d_flags got %b want %b", i, {out_valid, out_cout, out_ovf, out_zero}, eflg[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[8];
        logic [31:0] vb[8];
        logic        vs[8];
        res_t        e;
        int          n_issued, n_got, first_x, last_x;
        for (int i = 0; i < 8; i++) begin
            va[i] = $urandom();
            vb[i] = $urandom();
            vs[i] = 1'($urandom_range(0, 1));
        end
        exp_q.delete();
        n_issued = 0; n_got = 0; first_x = -1; last_x = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (n_issued < 8) begin
                in_valid = 1'b1; in_a = va[n_issued]; in_b = vb[n_issued]; in_sub = vs[n_issued];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra result %h at cycle %0d", out_sum, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_sum, out_cout, out_ovf, out_zero} !== e) begin
                        n_fail++;
                        $display("FAIL stream_result%0d got %h/%b%b%b want %h/%b%b%b", n_got,
                                 out_sum, out_cout, out_ovf, out_zero, e.sum, e.cout, e.ovf, e.zero);
                    end
                end
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                n_got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_sub));
                n_issued++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_got !== 8) begin n_fail++; $display("FAIL stream_count got %0d want 8", n_got); end
        n_checks++;
        if (last_x - first_x !== 7) begin
            n_fail++; $display("FAIL stream_contiguous got span %0d want 7", last_x - first_x);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] va[6];
        logic [31:0] vb[6];
        logic        vs[6];
        res_t        e, held;
        int          n_issued, n_got;
        va = '{32'h0000_0001, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vb = '{32'h0000_0002, 32'h0001_0000, 32'h0000_0001, 32'h0000_0010, 32'h1111_1111, 32'h0000_0000};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_q.delete();
        n_issued = 0; n_got = 0; held = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (n_issued < 6) begin
                in_valid = 1'b1; in_a = va[n_issued]; in_b = vb[n_issued]; in_sub = vs[n_issued];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 4 && cyc <= 6) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", cyc, in_ready); end
            end
            if (cyc >= 5 && cyc <= 7) begin
                n_checks++;
                if ({out_sum, out_cout, out_ovf, out_zero} !== held || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_hold cycle %0d got %h/%b%b%b v=%b want %h/%b%b%b v=1", cyc,
                             out_sum, out_cout, out_ovf, out_zero, out_valid, held.sum, held.cout, held.ovf, held.zero);
                end
            end
            if (cyc == 4) held = {out_sum, out_cout, out_ovf, out_zero};
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra result %h at cycle %0d", out_sum, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_sum, out_cout, out_ovf, out_zero} !== e) begin
                        n_fail++;
                        $display("FAIL bp_result%0d got %h/%b%b%b want %h/%b%b%b", n_got,
                                 out_sum, out_cout, out_ovf, out_zero, e.sum, e.cout, e.ovf, e.zero);
                    end
                end
                n_got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_sub));
                n_issued++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (n_got !== 6 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_count got %0d results, %0d pending want 6, 0", n_got, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = 32'h0100_0000 * i; in_b = 32'h0000_0003; in_sub = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid cycle %0d got %b want 0", i, out_valid); end
            tick();
        end
        send_op(32'h1234_5678, 32'h1111_1111, 1'b0);
        repeat (3) tick();
        n_checks++;
        if (out_sum !== 32'h2345_6789) begin n_fail++; $display("FAIL rstmid_sum got %h want 23456789", out_sum); end
        n_checks++;
        if ({out_valid, out_cout, out_ovf, out_zero} !== 4'b1000) begin
            n_fail++; $display("FAIL rstmid_flags got %b want 1000", {out_valid, out_cout, out_ovf, out_zero});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_carry_chain();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
